// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared definitions for the 8-bit LFSR test link.
//   NB_LFSR       word width used by generator and receiver
//   TAPS_DEFAULT  default feedback mask
//   NB_POP        width needed to hold a popcount of one word
//   state_t       receiver FSM encoding (SEARCH/VERIFY/LOCKED, code 3 unused)
//   lfsr_next()   one LFSR step: shift left, feedback parity into bit 0
//   popcount()    number of set bits in a word
// Both ends of the link import lfsr_next from here so their sequences cannot diverge.
package lfsr_pkg;

  localparam int NB_LFSR = 8;
  localparam logic [NB_LFSR-1:0] TAPS_DEFAULT = 8'hB8;
  localparam int NB_POP = $clog2(NB_LFSR + 1);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2,
    ST_UNUSED = 2'd3
  } state_t;

  function automatic logic [NB_LFSR-1:0] lfsr_next(input logic [NB_LFSR-1:0] x,
                                                   input logic [NB_LFSR-1:0] taps);
    return {x[NB_LFSR-2:0], ^(x & taps)};
  endfunction

  function automatic logic [NB_POP-1:0] popcount(input logic [NB_LFSR-1:0] x);
    logic [NB_POP-1:0] n;
    n = '0;
    for (int i = 0; i < NB_LFSR; i++) begin
      n = n + NB_POP'(x[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/lfsr_sat_counter.sv
// lfsr_sat_counter: saturating accumulator for link error statistics.
//   clk    in   system clock
//   rst    in   synchronous active-high reset, count <= 0
//   clear  in   synchronous clear, wins over a same-cycle increment
//   inc    in   amount to add this cycle (0 = hold)
//   count  out  running total, sticks at all-ones
module lfsr_sat_counter #(
  parameter int NB_CNT = 16,
  parameter int NB_INC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic [NB_INC-1:0] inc,
  output logic [NB_CNT-1:0] count
);

  // One extra bit catches the carry out that signals saturation.
  logic [NB_CNT:0] sum;

  assign sum = {1'b0, count} + (NB_CNT + 1)'(inc);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (sum[NB_CNT]) begin
      count <= '1;
    end else begin
      count <= sum[NB_CNT-1:0];
    end
  end

endmodule

// File: rtl/lfsr_sync_receiver.sv
// lfsr_sync_receiver: receive end of the 8-bit LFSR test link.
// Seeds its local LFSR from the incoming data, qualifies lock over LOCK_CNT
// consecutive matches, flywheels while locked, drops lock after LOSS_CNT
// consecutive mismatches and counts corrupted words.
// Optional build macro: LFSR_RX_BER_EN adds o_bit_err_count (mismatched-bit count).
// Ports:
//   clk              in   system clock, rising edge
//   i_rst            in   synchronous active-high reset
//   i_valid          in   i_lfsr carries a new word this cycle
//   i_lfsr           in   received LFSR word
//   i_clear          in   clear error counters (lock FSM untouched)
//   o_lock           out  1 while LOCKED
//   o_state          out  FSM state code
//   o_err            out  1-cycle pulse per mismatched word in VERIFY/LOCKED
//   o_err_count      out  saturating count of o_err pulses
//   o_bit_err_count  out  (LFSR_RX_BER_EN only) saturating count of mismatched bits
module lfsr_sync_receiver
  import lfsr_pkg::*;
#(
  parameter int                 NB_LFSR  = 8,  // must equal lfsr_pkg::NB_LFSR
  parameter logic [NB_LFSR-1:0] TAPS     = TAPS_DEFAULT,
  parameter int                 LOCK_CNT = 5,
  parameter int                 LOSS_CNT = 3,
  parameter int                 NB_CNT   = 16
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic               i_valid,
  input  logic [NB_LFSR-1:0] i_lfsr,
  input  logic               i_clear,
  output logic               o_lock,
  output logic [1:0]         o_state,
  output logic               o_err,
  output logic [NB_CNT-1:0]  o_err_count
`ifdef LFSR_RX_BER_EN
  ,
  output logic [NB_CNT-1:0]  o_bit_err_count
`endif
);

  localparam int NB_M = $clog2(LOCK_CNT + 1);
  localparam int NB_L = $clog2(LOSS_CNT + 1);

  state_t             state;
  logic [NB_LFSR-1:0] expected;
  logic [NB_M-1:0]    match;
  logic [NB_L-1:0]    miss;
  logic               word_match;
  logic               err_hit;

  assign word_match = (i_lfsr == expected);
  // A word is an error only when the receiver has a prediction to compare with.
  assign err_hit    = i_valid && !word_match &&
                      ((state == ST_VERIFY) || (state == ST_LOCKED));

  assign o_state = state;
  assign o_lock  = (state == ST_LOCKED);

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state    <= ST_SEARCH;
      expected <= '0;
      match    <= '0;
      miss     <= '0;
      o_err    <= 1'b0;
    end else begin
      o_err <= err_hit;
      case (state)
        ST_SEARCH: begin
          // All-zero is the LFSR lockup word and can never seed a sequence.
          if (i_valid && (i_lfsr != '0)) begin
            expected <= lfsr_next(i_lfsr, TAPS);
            match    <= '0;
            miss     <= '0;
            state    <= ST_VERIFY;
          end
        end
        ST_VERIFY: begin
          if (i_valid) begin
            if (word_match) begin
              expected <= lfsr_next(expected, TAPS);
              if (match == NB_M'(LOCK_CNT - 1)) begin
                state <= ST_LOCKED;
                miss  <= '0;
              end else begin
                match <= match + 1'b1;
              end
            end else begin
              match <= '0;
              if (i_lfsr == '0) begin
                state <= ST_SEARCH;
              end else begin
                expected <= lfsr_next(i_lfsr, TAPS);
              end
            end
          end
        end
        ST_LOCKED: begin
          if (i_valid) begin
            // Flywheel: once locked, corrupted data must not disturb the prediction.
            expected <= lfsr_next(expected, TAPS);
            if (word_match) begin
              miss <= '0;
            end else if (miss == NB_L'(LOSS_CNT - 1)) begin
              miss  <= '0;
              state <= ST_SEARCH;
            end else begin
              miss <= miss + 1'b1;
            end
          end
        end
        default: state <= ST_SEARCH;
      endcase
    end
  end

  lfsr_sat_counter #(
    .NB_CNT (NB_CNT),
    .NB_INC (1)
  ) u_err_cnt (
    .clk   (clk),
    .rst   (i_rst),
    .clear (i_clear),
    .inc   (err_hit),
    .count (o_err_count)
  );

`ifdef LFSR_RX_BER_EN
  logic [NB_POP-1:0] bit_inc;

  assign bit_inc = err_hit ? popcount(i_lfsr ^ expected) : '0;

  lfsr_sat_counter #(
    .NB_CNT (NB_CNT),
    .NB_INC (NB_POP)
  ) u_bit_err_cnt (
    .clk   (clk),
    .rst   (i_rst),
    .clear (i_clear),
    .inc   (bit_inc),
    .count (o_bit_err_count)
  );
`else
  // Bit-error statistics not built: no popcount path.
`endif

endmodule

// File: tb/tb_lfsr_sync_receiver.sv
// Scoreboard bench for lfsr_sync_receiver. A default-width instance and a
// 4-bit-counter instance share the same stimulus so that counter saturation
// is reached quickly. Define LFSR_RX_BER_EN to also check o_bit_err_count.
module tb_lfsr_sync_receiver;

  localparam int LOCK_CNT = 5;
  localparam int LOSS_CNT = 3;
  localparam int MAX_CNT  = 65535;
  localparam int MAX_SAT  = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, valid, clear;
  logic [7:0] din;

  logic        lock, err, lock_s, err_s;
  logic [1:0]  state, state_s;
  logic [15:0] ecnt;
  logic [3:0]  ecnt_s;
`ifdef LFSR_RX_BER_EN
  logic [15:0] bcnt;
  logic [3:0]  bcnt_s;
`endif

  lfsr_sync_receiver dut (
    .clk         (clk),
    .i_rst       (rst),
    .i_valid     (valid),
    .i_lfsr      (din),
    .i_clear     (clear),
    .o_lock      (lock),
    .o_state     (state),
    .o_err       (err),
    .o_err_count (ecnt)
`ifdef LFSR_RX_BER_EN
    ,
    .o_bit_err_count (bcnt)
`endif
  );

  lfsr_sync_receiver #(.NB_CNT(4)) dut_sat (
    .clk         (clk),
    .i_rst       (rst),
    .i_valid     (valid),
    .i_lfsr      (din),
    .i_clear     (clear),
    .o_lock      (lock_s),
    .o_state     (state_s),
    .o_err       (err_s),
    .o_err_count (ecnt_s)
`ifdef LFSR_RX_BER_EN
    ,
    .o_bit_err_count (bcnt_s)
`endif
  );

  typedef struct {
    int lock;
    int st;
    int err;
    int cnt;
    int cnt_s;
    int bits;
    int bits_s;
  } exp_t;

  exp_t q[$];

  // Reference model state: high-level view of the receiver.
  int         m_st;       // 0 searching, 1 verifying, 2 locked
  logic [7:0] m_exp;      // next word the receiver predicts
  int         m_good;     // consecutive confirmed words while verifying
  int         m_bad;      // consecutive bad words while locked
  int         m_err;
  int         m_cnt, m_cnt_s, m_bits, m_bits_s;

  logic [7:0] g;          // transmitter-side LFSR value
  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [7:0] ref_next(input logic [7:0] x);
    int fb;
    fb = $countones(x & 8'hB8) % 2;
    return 8'(((int'(x) * 2) + fb) % 256);
  endfunction

  function automatic int sat_add(input int a, input int b, input int max);
    return (a + b > max) ? max : a + b;
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_step(input logic v, input logic [7:0] d, input logic c, input logic r);
    int hit, nb;
    if (r) begin
      m_st = 0; m_exp = 8'h00; m_good = 0; m_bad = 0; m_err = 0;
      m_cnt = 0; m_cnt_s = 0; m_bits = 0; m_bits_s = 0;
    end else begin
      hit = (v && (m_st == 1 || m_st == 2) && d != m_exp) ? 1 : 0;
      nb  = hit ? $countones(d ^ m_exp) : 0;
      m_err = hit;
      if (c) begin
        m_cnt = 0; m_cnt_s = 0; m_bits = 0; m_bits_s = 0;
      end else begin
        m_cnt    = sat_add(m_cnt, hit, MAX_CNT);
        m_cnt_s  = sat_add(m_cnt_s, hit, MAX_SAT);
        m_bits   = sat_add(m_bits, nb, MAX_CNT);
        m_bits_s = sat_add(m_bits_s, nb, MAX_SAT);
      end
      if (v) begin
        if (m_st == 0) begin
          if (d != 8'h00) begin
            m_exp = ref_next(d); m_good = 0; m_st = 1;
          end
        end else if (m_st == 1) begin
          if (hit == 0) begin
            m_good++;
            m_exp = ref_next(m_exp);
            if (m_good == LOCK_CNT) begin m_st = 2; m_bad = 0; end
          end else begin
            m_good = 0;
            if (d == 8'h00) m_st = 0;
            else m_exp = ref_next(d);
          end
        end else begin
          m_exp = ref_next(m_exp);
          if (hit == 0) m_bad = 0;
          else begin
            m_bad++;
            if (m_bad == LOSS_CNT) begin m_st = 0; m_bad = 0; end
          end
        end
      end
    end
  endtask

  // Drive one cycle of inputs and queue what the outputs must show after the edge.
  task automatic step(input logic v, input logic [7:0] d, input logic c, input logic r);
    exp_t e;
    rst = r; valid = v; din = d; clear = c;
    model_step(v, d, c, r);
    e.lock = (m_st == 2) ? 1 : 0;
    e.st = m_st; e.err = m_err;
    e.cnt = m_cnt; e.cnt_s = m_cnt_s; e.bits = m_bits; e.bits_s = m_bits_s;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic send_clean(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, g, 1'b0, 1'b0);
      g = ref_next(g);
    end
  endtask

  task automatic send_bad(input logic [7:0] mask);
    step(1'b1, g ^ mask, 1'b0, 1'b0);
    g = ref_next(g);
  endtask

  // Monitor: outputs are registered state, so one expectation per cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("lock",      int'(lock),    e.lock);
        check("state",     int'(state),   e.st);
        check("err",       int'(err),     e.err);
        check("err_count", int'(ecnt),    e.cnt);
        check("lock_w4",   int'(lock_s),  e.lock);
        check("err_count_w4", int'(ecnt_s), e.cnt_s);
`ifdef LFSR_RX_BER_EN
        check("bit_err_count",    int'(bcnt),   e.bits);
        check("bit_err_count_w4", int'(bcnt_s), e.bits_s);
`endif
      end
    end
  end

  initial begin
    logic [7:0] d;
    int r;
    rst = 1'b1; valid = 1'b0; din = 8'h00; clear = 1'b0;
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Lockup word in SEARCH is ignored.
    step(1'b1, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'h00, 1'b0, 1'b0);

    // Clean stream from 01 locks after 1 seed + 5 matches.
    g = 8'h01;
    send_clean(8);

    // Single bit-0 flip while locked.
    send_bad(8'h01);
    send_clean(4);

    // Three consecutive bad words drop lock, then relock.
    send_bad(8'h55); send_bad(8'h55); send_bad(8'h55);
    send_clean(8);

    // Four-bit error while locked.
    send_bad(8'h0F);
    send_clean(2);

    // Gaps in the middle of VERIFY.
    step(1'b0, 8'h00, 1'b0, 1'b1);
    g = 8'hA5;
    send_clean(3);
    for (int i = 0; i < 3; i++) step(1'b0, 8'($urandom), 1'b0, 1'b0);
    send_clean(4);

    // Reset with a valid word mid-VERIFY, then relock.
    step(1'b0, 8'h00, 1'b0, 1'b1);
    g = 8'h3C;
    send_clean(2);
    step(1'b1, g, 1'b0, 1'b1);
    g = ref_next(g);
    send_clean(7);

    // Random words in VERIFY: a stream of errors saturates the 4-bit counters.
    for (int i = 0; i < 24; i++) begin
      d = 8'($urandom_range(1, 255));
      step(1'b1, d, 1'b0, 1'b0);
    end
    // Clear coinciding with an error leaves 0.
    d = (m_st == 0) ? 8'h00 : m_exp ^ 8'h80;
    if (d == 8'h00) d = 8'h41;
    step(1'b1, d, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Randomized mix.
    g = 8'h01;
    for (int i = 0; i < 800; i++) begin
      r = $urandom_range(0, 999);
      if (r < 4) begin
        step(1'b0, 8'h00, 1'b0, 1'b1);
      end else if (r < 150) begin
        step(1'b0, 8'($urandom), ($urandom_range(0, 40) == 0), 1'b0);
      end else if (r < 170) begin
        g = 8'($urandom_range(1, 255));
        send_clean(1);
      end else if (r < 230) begin
        send_bad(8'($urandom_range(1, 255)));
      end else if (r < 236) begin
        step(1'b1, 8'h00, 1'b0, 1'b0);
      end else begin
        step(1'b1, g, ($urandom_range(0, 60) == 0), 1'b0);
        g = ref_next(g);
      end
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
